i2c_xfer_sched: RTL

I2C_XFER_SCHED -- requirements
Module: i2c_xfer_sched

---
 rtl/i2c_xfer_sched.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/i2c_xfer_sched.sv
// Two-requester I2C transaction scheduler: arbitrates, sequences address/data
// through the core FIFOs, drives the control bits and reports completion.
module i2c_xfer_sched #(
    parameter int unsigned TO_W   = 16,
    parameter int unsigned TO_MAX = 16'hFFFF
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [6:0] req0_addr,
    input  logic       req0_rw,
    input  logic [3:0] req0_len,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [6:0] req1_addr,
    input  logic       req1_rw,
    input  logic [3:0] req1_len,
    output logic [1:0] gnt,
    input  logic [7:0] wdata,
    input  logic       wdata_valid,
    output logic       wdata_ready,
    output logic [7:0] rdata,
    output logic       rdata_valid,
    output logic       done,
    output logic       done_err,
    output logic       cr_msms,
    output logic       cr_tx,
    output logic       cr_txak,
    output logic       tx_fifo_wr,
    output logic [7:0] tx_fifo_din,
    input  logic       tx_fifo_full,
    output logic       rx_fifo_rd,
    input  logic [7:0] rx_fifo_dout,
    input  logic       rx_fifo_empty,
    input  logic       irq_tx_err,
    input  logic       bus_busy
);

    typedef enum logic [2:0] {IDLE, ADDR, START, WR, RD, STOP, DONE} state_t;

    localparam logic [TO_W-1:0] TO_LIM = TO_W'(TO_MAX);
    localparam logic [TO_W-1:0] WD_ONE = TO_W'(1);

    state_t          state_q, state_d;
    logic [1:0]      gnt_q, gnt_d;
    logic [1:0]      rdy_q, rdy_d;
    logic            prio_q, prio_d;
    logic [6:0]      addr_q, addr_d;
    logic            rw_q, rw_d;
    logic [4:0]      cnt_q, cnt_d;
    logic [TO_W-1:0] wd_q, wd_d;
    logic            err_q, err_d;

    logic push_a, push_w, pop, wd_expired, win1, wr_rdy, active;

    assign wd_expired = (wd_q == TO_LIM);
    // prio_q names the requester that wins a tie
    assign win1   = req1_valid & (~req0_valid | prio_q);
    assign wr_rdy = (state_q == WR) && !tx_fifo_full && (cnt_q != 5'd0);

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        rdy_d   = 2'b00;
        prio_d  = prio_q;
        addr_d  = addr_q;
        rw_d    = rw_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        push_a  = 1'b0;
        push_w  = 1'b0;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if ((req0_valid || req1_valid) && !bus_busy) begin
                    gnt_d   = win1 ? 2'b10 : 2'b01;
                    rdy_d   = win1 ? 2'b10 : 2'b01;
                    addr_d  = win1 ? req1_addr : req0_addr;
                    rw_d    = win1 ? req1_rw : req0_rw;
                    cnt_d   = {1'b0, (win1 ? req1_len : req0_len)} + 5'd1;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                if (!tx_fifo_full) begin
                    push_a  = 1'b1;
                    state_d = START;
                end else if (wd_expired) begin
                    err_d   = 1'b1;
                    state_d = STOP;
                end
            end
            START: begin
                if (irq_tx_err || wd_expired) begin
                    err_d   = 1'b1;
                    state_d = STOP;
                end else begin
                    state_d = rw_q ? RD : WR;
                end
            end
            WR, RD: begin
                push_w = (state_q == WR) && wr_rdy && wdata_valid;
                pop    = (state_q == RD) && !rx_fifo_empty && (cnt_q != 5'd0);
                if (push_w || pop)
                    cnt_d = cnt_q - 5'd1;
                // a transfer coinciding with an error still completes
                if (irq_tx_err || wd_expired) begin
                    err_d   = 1'b1;
                    state_d = STOP;
                end else if (cnt_d == 5'd0) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (wd_expired)
                    err_d = 1'b1;
                if (!bus_busy || wd_expired)
                    state_d = DONE;
            end
            DONE: begin
                gnt_d   = 2'b00;
                err_d   = 1'b0;
                prio_d  = gnt_q[0];
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wd_d = wd_q;
        if ((state_d != state_q) || push_a || push_w || pop ||
            (state_q == IDLE) || (state_q == DONE))
            wd_d = '0;
        else if (!wd_expired)
            wd_d = wd_q + WD_ONE;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            gnt_q   <= 2'b00;
            rdy_q   <= 2'b00;
            prio_q  <= 1'b0;
            addr_q  <= 7'd0;
            rw_q    <= 1'b0;
            cnt_q   <= 5'd0;
            wd_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            rdy_q   <= rdy_d;
            prio_q  <= prio_d;
            addr_q  <= addr_d;
            rw_q    <= rw_d;
            cnt_q   <= cnt_d;
            wd_q    <= wd_d;
            err_q   <= err_d;
        end
    end

    assign active      = (state_q == START) || (state_q == WR) || (state_q == RD);
    assign req0_ready  = rdy_q[0];
    assign req1_ready  = rdy_q[1];
    assign gnt         = gnt_q;
    assign wdata_ready = wr_rdy;
    assign tx_fifo_wr  = push_a | push_w;
    assign tx_fifo_din = push_a ? {addr_q, rw_q} : (push_w ? wdata : 8'h00);
    assign rx_fifo_rd  = pop;
    assign rdata       = pop ? rx_fifo_dout : 8'h00;
    assign rdata_valid = pop;
    assign done        = (state_q == DONE);
    assign done_err    = (state_q == DONE) & err_q;
    assign cr_msms     = active;
    assign cr_tx       = active & ~rw_q;
    assign cr_txak     = active & rw_q & (cnt_q <= 5'd1);

endmodule
